// File: rtl/sram_arb_ctrl_if.sv
// Bus bundle for sram_arb_ctrl: two requester ports, the macro side
// and the init-done flag.
interface sram_arb_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              INIT_DONE;

  logic              P0_REQ;
  logic              P0_WE;
  logic [ADDR_W-1:0] P0_A;
  logic [DATA_W-1:0] P0_D;
  logic              P0_GNT;
  logic              P0_RVALID;
  logic [DATA_W-1:0] P0_Q;

  logic              P1_REQ;
  logic              P1_WE;
  logic [ADDR_W-1:0] P1_A;
  logic [DATA_W-1:0] P1_D;
  logic              P1_GNT;
  logic              P1_RVALID;
  logic [DATA_W-1:0] P1_Q;

  logic              M_CS;
  logic              M_WE;
  logic [ADDR_W-1:0] M_A;
  logic [DATA_W-1:0] M_D;
  logic [DATA_W-1:0] M_Q;

  modport slave (
    output INIT_DONE,
    input  P0_REQ, P0_WE, P0_A, P0_D,
    output P0_GNT, P0_RVALID, P0_Q,
    input  P1_REQ, P1_WE, P1_A, P1_D,
    output P1_GNT, P1_RVALID, P1_Q,
    output M_CS, M_WE, M_A, M_D,
    input  M_Q
  );

  modport master (
    input  INIT_DONE,
    output P0_REQ, P0_WE, P0_A, P0_D,
    input  P0_GNT, P0_RVALID, P0_Q,
    output P1_REQ, P1_WE, P1_A, P1_D,
    input  P1_GNT, P1_RVALID, P1_Q,
    input  M_CS, M_WE, M_A, M_D,
    output M_Q
  );
endinterface

// File: rtl/sram_arb_ctrl.sv
// Two-port round-robin controller for a single 1RW SRAM macro.
// Zero-fills the array after reset, then serves single-beat accesses.
module sram_arb_ctrl #(
  parameter int               ADDR_W   = 8,
  parameter int               DATA_W   = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter bit               INIT_EN  = 1'b1
) (
  input  logic            CK,
  input  logic            RST,
  sram_arb_ctrl_if.slave  bus
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_A = '1;
  localparam state_t RST_STATE = INIT_EN ? ST_INIT : ST_RUN;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;

  logic              gnt0, gnt1;
  logic              m_cs, m_we;
  logic [ADDR_W-1:0] m_a;
  logic [DATA_W-1:0] m_d;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  // rr_q = 0 favours port 0 on a tie; it flips to the loser after a grant
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    m_cs    = 1'b0;
    m_we    = 1'b0;
    m_a     = '0;
    m_d     = '0;
    if (!RST) begin
      unique case (state_q)
        ST_INIT: begin
          m_cs = 1'b1;
          m_we = 1'b1;
          m_a  = cnt_q;
          m_d  = INIT_VAL;
          if (cnt_q == LAST_A) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          gnt0 = bus.P0_REQ && (!bus.P1_REQ || !rr_q);
          gnt1 = bus.P1_REQ && (!bus.P0_REQ || rr_q);
          unique case (1'b1)
            gnt0: begin
              m_cs  = 1'b1;
              m_we  = bus.P0_WE;
              m_a   = bus.P0_A;
              m_d   = bus.P0_D;
              rr_d  = 1'b1;
              rv0_d = !bus.P0_WE;
            end
            gnt1: begin
              m_cs  = 1'b1;
              m_we  = bus.P1_WE;
              m_a   = bus.P1_A;
              m_d   = bus.P1_D;
              rr_d  = 1'b0;
              rv1_d = !bus.P1_WE;
            end
            default: begin
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.INIT_DONE = (state_q == ST_RUN);

  assign bus.P0_GNT    = gnt0;
  assign bus.P1_GNT    = gnt1;
  assign bus.P0_RVALID = rv0_q;
  assign bus.P1_RVALID = rv1_q;
  assign bus.P0_Q      = bus.M_Q;
  assign bus.P1_Q      = bus.M_Q;

  assign bus.M_CS      = m_cs;
  assign bus.M_WE      = m_we;
  assign bus.M_A       = m_a;
  assign bus.M_D       = m_d;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scoreboard bench for sram_arb_ctrl: directed accesses on a default
// instance plus a no-init instance.
module tb_sram_arb_ctrl;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic rst_a;
  logic rst_b;

  sram_arb_ctrl_if #(.ADDR_W(8), .DATA_W(16)) ba ();
  sram_arb_ctrl_if #(.ADDR_W(4), .DATA_W(16)) bb ();

  sram_arb_ctrl #(
    .ADDR_W(8), .DATA_W(16), .INIT_VAL(16'h0000), .INIT_EN(1'b1)
  ) dut_a (
    .CK(CK), .RST(rst_a), .bus(ba.slave)
  );

  sram_arb_ctrl #(
    .ADDR_W(4), .DATA_W(16), .INIT_VAL(16'hABCD), .INIT_EN(1'b0)
  ) dut_b (
    .CK(CK), .RST(rst_b), .bus(bb.slave)
  );

  // behavioural 1RW macros, registered read-before-write Q
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [16];

  always @(posedge CK) begin
    if (ba.M_CS) begin
      if (ba.M_WE) mem_a[ba.M_A] <= ba.M_D;
      ba.M_Q <= mem_a[ba.M_A];
    end
  end

  always @(posedge CK) begin
    if (bb.M_CS) begin
      if (bb.M_WE) mem_b[bb.M_A] <= bb.M_D;
      bb.M_Q <= mem_b[bb.M_A];
    end
  end

  typedef struct {
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every RVALID must match the oldest expected read
  always @(negedge CK) begin
    if (ba.P0_RVALID && ba.P1_RVALID) chk("rvalid_both", 1, 0);
    if (ba.P0_RVALID) begin
      if (q0.size() == 0) begin
        chk("p0_rvalid_unexpected", 1, 0);
      end else begin
        e0 = q0.pop_front();
        chk("p0_rvalid_cycle", cyc, e0.cyc);
        chk("p0_q", {16'h0, ba.P0_Q}, {16'h0, e0.d});
      end
    end
    if (ba.P1_RVALID) begin
      if (q1.size() == 0) begin
        chk("p1_rvalid_unexpected", 1, 0);
      end else begin
        e1 = q1.pop_front();
        chk("p1_rvalid_cycle", cyc, e1.cyc);
        chk("p1_q", {16'h0, ba.P1_Q}, {16'h0, e1.d});
      end
    end
  end

  task automatic push(input int p, input logic [15:0] d);
    if (p == 0) q0.push_back('{d, cyc + 1});
    else        q1.push_back('{d, cyc + 1});
  endtask

  // called at posedge+1; returns with the request dropped at posedge+1
  task automatic op_a(input int p, input bit we, input logic [7:0] a,
                      input logic [15:0] d, input logic [15:0] ex,
                      output int waits);
    bit g;
    if (p == 0) begin
      ba.P0_WE = we; ba.P0_A = a; ba.P0_D = d; ba.P0_REQ = 1'b1;
    end else begin
      ba.P1_WE = we; ba.P1_A = a; ba.P1_D = d; ba.P1_REQ = 1'b1;
    end
    waits = 0;
    forever begin
      @(negedge CK);
      g = (p == 0) ? ba.P0_GNT : ba.P1_GNT;
      if (g) break;
      waits++;
      if (waits > 20) begin
        chk("grant_timeout", 0, 1);
        break;
      end
    end
    if (g && !we) push(p, ex);
    @(posedge CK);
    #1;
    if (p == 0) ba.P0_REQ = 1'b0;
    else        ba.P1_REQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ba.P0_REQ = 1'b1; ba.P0_WE = 1'b0; ba.P0_A = 8'h01; ba.P0_D = '0;
    ba.P1_REQ = 1'b1; ba.P1_WE = 1'b0; ba.P1_A = 8'h02; ba.P1_D = '0;
    bb.P0_REQ = 1'b0; bb.P0_WE = 1'b0; bb.P0_A = '0; bb.P0_D = '0;
    bb.P1_REQ = 1'b0; bb.P1_WE = 1'b0; bb.P1_A = '0; bb.P1_D = '0;

    // reset state
    repeat (2) @(posedge CK);
    @(negedge CK);
    chk("rst_state",
        {ba.INIT_DONE, ba.P0_GNT, ba.P1_GNT, ba.P0_RVALID,
         ba.P1_RVALID, ba.M_CS, ba.M_WE}, 7'b0);

    // init sweep with both requests pending
    @(posedge CK);
    #1 rst_a = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge CK);
      chk($sformatf("init_cycle_%0d", i),
          {ba.M_CS, ba.M_WE, ba.P0_GNT, ba.P1_GNT, ba.INIT_DONE,
           ba.M_A, ba.M_D},
          {5'b11000, 8'(i), 16'h0000});
    end

    // both reading continuously: P0 first, then alternating
    for (int k = 0; k < 4; k++) begin
      @(negedge CK);
      chk($sformatf("run_done_%0d", k), ba.INIT_DONE, 1);
      chk($sformatf("alt_grant_%0d", k), {ba.P0_GNT, ba.P1_GNT},
          (k % 2 == 0) ? 2'b10 : 2'b01);
      if (ba.P0_GNT) push(0, 16'h0000);
      if (ba.P1_GNT) push(1, 16'h0000);
    end
    @(posedge CK);
    #1;
    ba.P0_REQ = 1'b0;
    ba.P1_REQ = 1'b0;

    // write then read back on port 0
    op_a(0, 1'b1, 8'h12, 16'hBEEF, 16'h0000, w);
    chk("wr12_wait", w, 0);
    op_a(0, 1'b0, 8'h12, 16'h0000, 16'hBEEF, w);
    chk("rd12_wait", w, 0);

    // port 1 alone, three cycles
    for (int k = 0; k < 3; k++) begin
      op_a(1, 1'b0, 8'h02, 16'h0000, 16'h0000, w);
      chk($sformatf("p1_alone_wait_%0d", k), w, 0);
    end

    // tie after a P1 grant goes to P0
    ba.P0_WE = 1'b0; ba.P0_A = 8'h01; ba.P0_REQ = 1'b1;
    ba.P1_WE = 1'b0; ba.P1_A = 8'h02; ba.P1_REQ = 1'b1;
    @(negedge CK);
    chk("tie_p0_wins", {ba.P0_GNT, ba.P1_GNT}, 2'b10);
    if (ba.P0_GNT) push(0, 16'h0000);
    @(posedge CK);
    #1 ba.P0_REQ = 1'b0;
    @(negedge CK);
    chk("tie_p1_next", {ba.P0_GNT, ba.P1_GNT}, 2'b01);
    if (ba.P1_GNT) push(1, 16'h0000);
    @(posedge CK);
    #1 ba.P1_REQ = 1'b0;

    // cross-port write/read ordering
    op_a(1, 1'b1, 8'h05, 16'h1234, 16'h0000, w);
    chk("p1_wr05_wait", w, 0);
    op_a(0, 1'b0, 8'h05, 16'h0000, 16'h1234, w);
    chk("p0_rd05_wait", w, 0);

    repeat (2) @(posedge CK);
    #1;
    @(negedge CK);
    chk("idle_macro", {ba.M_CS, ba.M_WE}, 2'b00);

    // reset while a P1 read is granted
    @(posedge CK);
    #1;
    ba.P1_WE = 1'b0; ba.P1_A = 8'h12; ba.P1_REQ = 1'b1;
    @(negedge CK);
    chk("p1_pre_rst_gnt", ba.P1_GNT, 1);
    #1 rst_a = 1'b1;
    ba.P1_REQ = 1'b0;
    @(negedge CK);
    chk("rst_mid_rvalid", {ba.P1_RVALID, ba.P0_RVALID}, 2'b00);
    chk("rst_mid_done", ba.INIT_DONE, 0);
    @(posedge CK);
    #1 rst_a = 1'b0;
    @(negedge CK);
    chk("reinit_start", {ba.M_CS, ba.M_WE, ba.M_A}, {2'b11, 8'h00});
    n = 0;
    while (!ba.INIT_DONE && n < 400) begin
      @(negedge CK);
      n++;
    end
    chk("reinit_done", ba.INIT_DONE, 1);
    chk("reinit_len", n, 256);
    @(posedge CK);
    #1;
    op_a(0, 1'b0, 8'h12, 16'h0000, 16'h0000, w);
    chk("rd12_after_reinit_wait", w, 0);

    repeat (3) @(posedge CK);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    // instance without init sweep
    bb.P0_WE = 1'b1; bb.P0_A = 4'h7; bb.P0_D = 16'h5A5A; bb.P0_REQ = 1'b1;
    @(posedge CK);
    #1 rst_b = 1'b0;
    @(negedge CK);
    chk("noinit_first",
        {bb.INIT_DONE, bb.P0_GNT, bb.M_CS, bb.M_WE, bb.M_A, bb.M_D},
        {4'b1111, 4'h7, 16'h5A5A});
    @(posedge CK);
    #1;
    bb.P0_REQ = 1'b0;
    bb.P1_WE = 1'b0; bb.P1_A = 4'h7; bb.P1_REQ = 1'b1;
    @(negedge CK);
    chk("noinit_p1_gnt", bb.P1_GNT, 1);
    chk("noinit_wr_no_rvalid", bb.P0_RVALID, 0);
    @(posedge CK);
    #1 bb.P1_REQ = 1'b0;
    @(negedge CK);
    chk("noinit_rvalid", {bb.P1_RVALID, bb.P0_RVALID}, 2'b10);
    chk("noinit_q", {16'h0, bb.P1_Q}, {16'h0, 16'h5A5A});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
